// File: rtl/plic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plic_pkg
// Description : Shared types for the interrupt gateway. Holds the per-channel
//               trigger-mode encoding, the channel FSM state encoding and the
//               helper that decodes the "off" modes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package plic_pkg;

    // Per-channel trigger mode; 110 and 111 are reserved and behave as off.
    typedef enum logic [2:0] {
        MODE_OFF      = 3'b000,
        MODE_RISE     = 3'b001,
        MODE_FALL     = 3'b010,
        MODE_BOTH     = 3'b011,
        MODE_LEVEL_HI = 3'b100,
        MODE_LEVEL_LO = 3'b101,
        MODE_RSVD6    = 3'b110,
        MODE_RSVD7    = 3'b111
    } irq_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_CLAIMED = 2'd2
    } ch_state_e;

    function automatic logic mode_is_off(input logic [2:0] mode);
        return (mode == MODE_OFF) || (mode[2:1] == 2'b11);
    endfunction

endpackage : plic_pkg
`default_nettype wire

// File: rtl/irq_gw_channel.sv
`default_nettype none
// ============================================================================
// Module      : irq_gw_channel
// Description : One interrupt channel: synchroniser, glitch filter, event
//               detector and IDLE/PENDING/CLAIMED service FSM with rearm and
//               sticky overflow tracking.
// Ports       : pclk, preset_n        - clock, async active-low reset
//               irq_raw               - asynchronous interrupt source
//               cfg_mode, cfg_filt    - trigger mode, filter stable count
//               claim_hit             - legal claim addressed to this channel
//               complete_hit          - legal complete addressed to this channel
//               pending, claimed      - registered FSM state decodes
//               overflow              - sticky lost-edge flag
// Revision    : 1.0 - initial release
// ============================================================================
module irq_gw_channel
    import plic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              irq_raw,
    input  logic [2:0]        cfg_mode,
    input  logic [FILT_W-1:0] cfg_filt,
    input  logic              claim_hit,
    input  logic              complete_hit,
    output logic              pending,
    output logic              claimed,
    output logic              overflow
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   filt_q, filt_d;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    ch_state_e              state_q, state_d;
    logic                   rearm_q, rearm_d;
    logic                   overflow_q, overflow_d;
    logic                   rise, fall, edge_evt, level_cond, off;

    assign synced = sync_q[SYNC_STAGES-1];

    // Glitch filter: the counter tracks how many earlier consecutive cycles
    // the synchronised value has disagreed with the filtered value, so the
    // update lands on the (cfg_filt+1)-th disagreeing cycle.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (synced != filt_q) begin
            if (cnt_q >= cfg_filt) begin
                filt_d = synced;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Edges are taken from the filter output being loaded this cycle so the
    // FSM reacts on the same edge the filtered value changes; levels use the
    // registered filtered value.
    assign rise = filt_d & ~filt_q;
    assign fall = filt_q & ~filt_d;
    assign off  = mode_is_off(cfg_mode);

    always_comb begin
        edge_evt   = 1'b0;
        level_cond = 1'b0;
        case (cfg_mode)
            MODE_RISE:     edge_evt   = rise;
            MODE_FALL:     edge_evt   = fall;
            MODE_BOTH:     edge_evt   = rise | fall;
            MODE_LEVEL_HI: level_cond = filt_q;
            MODE_LEVEL_LO: level_cond = ~filt_q;
            default:       ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rearm_d    = rearm_q;
        overflow_d = overflow_q;
        if (off) begin
            state_d = ST_IDLE;
            rearm_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (edge_evt || level_cond) begin
                        state_d = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    // A request is already queued; a further edge is lost.
                    if (edge_evt) begin
                        overflow_d = 1'b1;
                    end
                    if (claim_hit) begin
                        state_d = ST_CLAIMED;
                    end
                end
                ST_CLAIMED: begin
                    if (edge_evt && rearm_q) begin
                        overflow_d = 1'b1;
                    end
                    if (complete_hit) begin
                        rearm_d = 1'b0;
                        // An edge arriving with the complete counts as a rearm.
                        state_d = (rearm_q || edge_evt || level_cond) ? ST_PENDING : ST_IDLE;
                    end else if (edge_evt) begin
                        rearm_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sync_q     <= '0;
            filt_q     <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            rearm_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            rearm_q    <= rearm_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending  = (state_q == ST_PENDING);
    assign claimed  = (state_q == ST_CLAIMED);
    assign overflow = overflow_q;

endmodule : irq_gw_channel
`default_nettype wire

// File: rtl/irq_gateway.sv
`default_nettype none
// ============================================================================
// Module      : irq_gateway
// Description : Multi-channel interrupt gateway. Instantiates one
//               irq_gw_channel per source and decodes the claim/complete
//               handshake, flagging illegal requests on hs_err.
// Ports       : pclk, preset_n             - clock, async active-low reset
//               irq_raw[NUM_CH]            - asynchronous interrupt sources
//               cfg_mode[NUM_CH*3]         - per-channel mode, 3 bits each
//               cfg_filt[FILT_W]           - global filter stable count
//               claim_valid/claim_id       - one-cycle claim request
//               complete_valid/complete_id - one-cycle completion
//               pending, claimed, overflow - per-channel status
//               hs_err                     - pulse after an illegal request
// Revision    : 1.0 - initial release
// ============================================================================
module irq_gateway
    import plic_pkg::*;
#(
    parameter  int NUM_CH      = 8,
    parameter  int SYNC_STAGES = 2,
    parameter  int FILT_W      = 4,
    localparam int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic [NUM_CH-1:0]   irq_raw,
    input  logic [NUM_CH*3-1:0] cfg_mode,
    input  logic [FILT_W-1:0]   cfg_filt,
    input  logic                claim_valid,
    input  logic [ID_W-1:0]     claim_id,
    input  logic                complete_valid,
    input  logic [ID_W-1:0]     complete_id,
    output logic [NUM_CH-1:0]   pending,
    output logic [NUM_CH-1:0]   claimed,
    output logic [NUM_CH-1:0]   overflow,
    output logic                hs_err
);

    logic [NUM_CH-1:0] claim_hit;
    logic [NUM_CH-1:0] complete_hit;
    logic              claim_bad;
    logic              complete_bad;

    // A request only reaches a channel when it is in the matching state, so
    // an empty hit vector means wrong state or an id past the last channel.
    // Both decodes read the registered state, making a same-cycle claim and
    // complete independent of each other.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (claim_valid && (claim_id == ID_W'(i))) begin
                claim_hit[i] = pending[i];
            end
            if (complete_valid && (complete_id == ID_W'(i))) begin
                complete_hit[i] = claimed[i];
            end
        end
    end

    assign claim_bad    = claim_valid    & ~(|claim_hit);
    assign complete_bad = complete_valid & ~(|complete_hit);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            hs_err <= 1'b0;
        end else begin
            hs_err <= claim_bad | complete_bad;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        irq_gw_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_ch (
            .pclk         (pclk),
            .preset_n     (preset_n),
            .irq_raw      (irq_raw[g]),
            .cfg_mode     (cfg_mode[g*3 +: 3]),
            .cfg_filt     (cfg_filt),
            .claim_hit    (claim_hit[g]),
            .complete_hit (complete_hit[g]),
            .pending      (pending[g]),
            .claimed      (claimed[g]),
            .overflow     (overflow[g])
        );
    end

endmodule : irq_gateway
`default_nettype wire

// File: tb/tb_irq_gateway.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_gateway
// Description : Self-checking bench for irq_gateway. Six channels are used so
//               that ids 6 and 7 exist on the 3-bit id bus and exercise the
//               out-of-range path. A behavioural model (window-based filter,
//               per-channel service state) is compared every cycle, alongside
//               a directed vector table and hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_gateway;

    localparam int NUM_CH      = 6;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_W      = 4;
    localparam int ID_W        = 3;

    logic                pclk = 1'b0;
    logic                preset_n;
    logic [NUM_CH-1:0]   irq_raw;
    logic [NUM_CH*3-1:0] cfg_mode;
    logic [FILT_W-1:0]   cfg_filt;
    logic                claim_valid, complete_valid;
    logic [ID_W-1:0]     claim_id, complete_id;
    logic [NUM_CH-1:0]   pending, claimed, overflow;
    logic                hs_err;

    int checks = 0;
    int errors = 0;

    irq_gateway #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
    ) dut (
        .pclk           (pclk),
        .preset_n       (preset_n),
        .irq_raw        (irq_raw),
        .cfg_mode       (cfg_mode),
        .cfg_filt       (cfg_filt),
        .claim_valid    (claim_valid),
        .claim_id       (claim_id),
        .complete_valid (complete_valid),
        .complete_id    (complete_id),
        .pending        (pending),
        .claimed        (claimed),
        .overflow       (overflow),
        .hs_err         (hs_err)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. The filter is expressed as a history window: the
    // filtered value takes the synchronised value once the last cfg_filt+1
    // synchronised samples all equal it and it differs from the current
    // filtered value. State: 0 idle, 1 pending, 2 claimed.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] m_hist[$];
    int                m_st   [NUM_CH];
    bit                m_filt [NUM_CH];
    bit                m_rearm[NUM_CH];
    bit                m_ovf  [NUM_CH];
    bit                m_hs;

    function automatic logic [NUM_CH-1:0] m_sample(input int ago);
        if (ago <= m_hist.size()) return m_hist[m_hist.size() - ago];
        return '0;
    endfunction

    task automatic model_step();
        int  ci, ki;
        bit  claim_ok, comp_ok, x, stable, newf, rise, fall, edge_ev, lvl, off;
        logic [2:0]        md;
        logic [NUM_CH-1:0] smp;
        ci = int'(claim_id);
        ki = int'(complete_id);
        claim_ok = 1'b0;
        comp_ok  = 1'b0;
        if (claim_valid && ci < NUM_CH) claim_ok = (m_st[ci] == 1);
        if (complete_valid && ki < NUM_CH) comp_ok = (m_st[ki] == 2);
        m_hs = (claim_valid && !claim_ok) || (complete_valid && !comp_ok);
        for (int c = 0; c < NUM_CH; c++) begin
            smp = m_sample(SYNC_STAGES);
            x = smp[c];
            stable = 1'b1;
            for (int j = 0; j <= int'(cfg_filt); j++) begin
                smp = m_sample(SYNC_STAGES + j);
                if (smp[c] != x) stable = 1'b0;
            end
            newf = (stable && (x != m_filt[c])) ? x : m_filt[c];
            rise = newf && !m_filt[c];
            fall = m_filt[c] && !newf;
            md   = cfg_mode[c*3 +: 3];
            off  = (md == 3'd0) || (md >= 3'd6);
            edge_ev = (md == 3'd1 && rise) || (md == 3'd2 && fall) || (md == 3'd3 && (rise || fall));
            lvl     = (md == 3'd4 && m_filt[c]) || (md == 3'd5 && !m_filt[c]);
            if (off) begin
                m_st[c] = 0;
                m_rearm[c] = 1'b0;
            end else if (m_st[c] == 0) begin
                if (edge_ev || lvl) m_st[c] = 1;
            end else if (m_st[c] == 1) begin
                if (edge_ev) m_ovf[c] = 1'b1;
                if (claim_ok && ci == c) m_st[c] = 2;
            end else begin
                if (edge_ev && m_rearm[c]) m_ovf[c] = 1'b1;
                if (comp_ok && ki == c) begin
                    m_st[c] = (m_rearm[c] || edge_ev || lvl) ? 1 : 0;
                    m_rearm[c] = 1'b0;
                end else if (edge_ev) begin
                    m_rearm[c] = 1'b1;
                end
            end
            m_filt[c] = newf;
        end
        m_hist.push_back(irq_raw);
        if (m_hist.size() > 40) void'(m_hist.pop_front());
    endtask

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            m_hist.delete();
            m_hs = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_st[c] = 0; m_filt[c] = 1'b0; m_rearm[c] = 1'b0; m_ovf[c] = 1'b0;
            end
        end else begin
            model_step();
        end
    end

    always @(posedge pclk) begin
        logic [NUM_CH-1:0] ep, ec, eo;
        #1;
        if (preset_n === 1'b1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ep[c] = (m_st[c] == 1);
                ec[c] = (m_st[c] == 2);
                eo[c] = m_ovf[c];
            end
            chk("model_pending",  pending,  ep);
            chk("model_claimed",  claimed,  ec);
            chk("model_overflow", overflow, eo);
            chk("model_hs_err",   hs_err,   m_hs);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic clk1();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_mode(input int ch, input logic [2:0] m);
        cfg_mode[ch*3 +: 3] = m;
    endtask

    task automatic do_claim(input int id);
        claim_valid = 1'b1;
        claim_id = ID_W'(id);
        clk1();
        claim_valid = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete_valid = 1'b1;
        complete_id = ID_W'(id);
        clk1();
        complete_valid = 1'b0;
    endtask

    task automatic wait_pend(input int ch, input int max_cyc, input string name);
        int n;
        n = 0;
        while (!pending[ch] && n < max_cyc) begin
            clk1();
            n++;
        end
        chk(name, pending[ch], 1);
    endtask

    // Retrigger one edge on a rise-mode source: low 4 cycles, high 4 cycles.
    task automatic pulse_low_high(input int ch);
        irq_raw[ch] = 1'b0;
        repeat (4) clk1();
        irq_raw[ch] = 1'b1;
        repeat (4) clk1();
    endtask

    typedef struct {
        logic [NUM_CH-1:0] raw;
        logic              cv;
        logic [ID_W-1:0]   cid;
        logic              kv;
        logic [ID_W-1:0]   kid;
        logic [NUM_CH-1:0] exp_pend;
        logic [NUM_CH-1:0] exp_clm;
        logic              exp_hs;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [2:0] rm;
        int         pick;

        preset_n = 1'b0;
        irq_raw = '0; cfg_mode = '0; cfg_filt = '0;
        claim_valid = 1'b0; claim_id = '0;
        complete_valid = 1'b0; complete_id = '0;
        repeat (3) clk1();
        chk("reset_pending",  pending,  0);
        chk("reset_claimed",  claimed,  0);
        chk("reset_overflow", overflow, 0);
        chk("reset_hs_err",   hs_err,   0);

        // Channel 3 rising edge, 3-cycle latency, claim/complete and the
        // illegal handshake cases. Rows: inputs for one cycle, expected
        // outputs after that cycle's edge.
        tbl[0] = '{6'h08, 1'b0, 3'd0, 1'b0, 3'd0, 6'h00, 6'h00, 1'b0};
        tbl[1] = '{6'h08, 1'b0, 3'd0, 1'b0, 3'd0, 6'h00, 6'h00, 1'b0};
        tbl[2] = '{6'h08, 1'b0, 3'd0, 1'b0, 3'd0, 6'h08, 6'h00, 1'b0};
        tbl[3] = '{6'h08, 1'b1, 3'd3, 1'b0, 3'd0, 6'h00, 6'h08, 1'b0};
        tbl[4] = '{6'h08, 1'b1, 3'd5, 1'b0, 3'd0, 6'h00, 6'h08, 1'b1};
        tbl[5] = '{6'h08, 1'b0, 3'd0, 1'b0, 3'd0, 6'h00, 6'h08, 1'b0};
        tbl[6] = '{6'h08, 1'b0, 3'd0, 1'b1, 3'd7, 6'h00, 6'h08, 1'b1};
        tbl[7] = '{6'h08, 1'b0, 3'd0, 1'b1, 3'd3, 6'h00, 6'h00, 1'b0};
        tbl[8] = '{6'h08, 1'b1, 3'd3, 1'b0, 3'd0, 6'h00, 6'h00, 1'b1};
        tbl[9] = '{6'h00, 1'b0, 3'd0, 1'b0, 3'd0, 6'h00, 6'h00, 1'b0};

        set_mode(3, 3'b001);
        preset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            irq_raw = tbl[i].raw;
            claim_valid = tbl[i].cv;   claim_id = tbl[i].cid;
            complete_valid = tbl[i].kv; complete_id = tbl[i].kid;
            clk1();
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].exp_pend);
            chk($sformatf("tbl%0d_claimed", i), claimed, tbl[i].exp_clm);
            chk($sformatf("tbl%0d_hs_err", i),  hs_err,  tbl[i].exp_hs);
        end
        claim_valid = 1'b0; complete_valid = 1'b0;
        set_mode(3, 3'b000);
        clk1();

        // Filter: 3-cycle glitch rejected, 8-cycle pulse accepted after 7.
        cfg_filt = 4'd4;
        set_mode(0, 3'b011);
        irq_raw[0] = 1'b1;
        repeat (3) clk1();
        irq_raw[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            clk1();
            chk("glitch_no_pending", pending[0], 0);
        end
        irq_raw[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            clk1();
            chk($sformatf("filt_pending_c%0d", k), pending[0], (k >= 7));
        end
        irq_raw[0] = 1'b0;
        repeat (10) clk1();
        chk("both_fall_overflow", overflow[0], 1);
        set_mode(0, 3'b000);
        clk1();
        chk("off_forces_idle", pending[0], 0);
        chk("off_keeps_overflow", overflow[0], 1);
        cfg_filt = 4'd0;

        // Level-high: re-pends on complete while held, idles once released.
        set_mode(4, 3'b100);
        irq_raw[4] = 1'b1;
        wait_pend(4, 8, "level_pend");
        do_claim(4);
        chk("level_claimed", claimed[4], 1);
        do_complete(4);
        chk("level_repend", pending[4], 1);
        chk("level_repend_clm", claimed[4], 0);
        do_claim(4);
        irq_raw[4] = 1'b0;
        repeat (4) clk1();
        do_complete(4);
        chk("level_idle_pend", pending[4], 0);
        chk("level_idle_clm", claimed[4], 0);
        set_mode(4, 3'b000);

        // Rising edges while pending are lost and flag overflow.
        set_mode(1, 3'b001);
        irq_raw[1] = 1'b1;
        wait_pend(1, 8, "ovf_pend");
        chk("ovf_before", overflow[1], 0);
        pulse_low_high(1);
        pulse_low_high(1);
        chk("ovf_set", overflow[1], 1);
        chk("ovf_still_pend", pending[1], 1);
        do_claim(1);
        chk("ovf_sticky", overflow[1], 1);

        // One edge while claimed rearms without overflow.
        set_mode(5, 3'b001);
        irq_raw[5] = 1'b1;
        wait_pend(5, 8, "rearm_pend");
        do_claim(5);
        pulse_low_high(5);
        chk("rearm_claimed", claimed[5], 1);
        chk("rearm_no_ovf", overflow[5], 0);
        do_complete(5);
        chk("rearm_repend", pending[5], 1);
        chk("rearm_ovf_after", overflow[5], 0);

        // Asynchronous reset with channel 2 claimed and rearmed.
        set_mode(2, 3'b001);
        irq_raw[2] = 1'b1;
        wait_pend(2, 8, "rst_pend");
        do_claim(2);
        pulse_low_high(2);
        chk("rst_pre_claimed", claimed[2], 1);
        #2;
        preset_n = 1'b0;
        #1;
        chk("rst_async_pending",  pending,  0);
        chk("rst_async_claimed",  claimed,  0);
        chk("rst_async_overflow", overflow, 0);
        chk("rst_async_hs_err",   hs_err,   0);
        clk1();
        preset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            clk1();
            chk($sformatf("rst_held_high_c%0d", k), pending[2], (k == 3));
        end

        // Randomised traffic against the model.
        cfg_filt = FILT_W'($urandom_range(0, 2));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    rm = 3'($urandom_range(0, 7));
                    set_mode(c, rm);
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 7) == 0) irq_raw[c] = ~irq_raw[c];
            end
            claim_valid = ($urandom_range(0, 2) == 0);
            claim_id = ID_W'($urandom_range(0, 7));
            pick = int'($urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 1) == 0 && m_st[pick] == 1) claim_id = ID_W'(pick);
            complete_valid = ($urandom_range(0, 3) == 0);
            complete_id = ID_W'($urandom_range(0, 7));
            pick = int'($urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 1) == 0 && m_st[pick] == 2) complete_id = ID_W'(pick);
            clk1();
        end
        claim_valid = 1'b0;
        complete_valid = 1'b0;
        repeat (3) clk1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_irq_gateway
`default_nettype wire
